// File: rtl/eth_bus_arbiter.sv
// eth_bus_arbiter: req/gnt arbiter for the shared Ethernet controller bus (init/TX/RX), with turnaround gap.
// Optional ownership watchdog enabled by defining ETH_ARB_TIMEOUT_EN.
module eth_bus_arbiter #(
    parameter int TURN_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       init_req,
    input  logic       tx_req,
    input  logic       rx_req,
    output logic       init_gnt,
    output logic       tx_gnt,
    output logic       rx_gnt,
    output logic [1:0] ctl,
    output logic       init_done,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
        $error("eth_bus_arbiter: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] ctl_q, ctl_d;
    logic [3:0] turn_q, turn_d;
    logic       last_rx_q, last_rx_d;
    logic       init_done_q, init_done_d;
    logic       busy_q, busy_d;
    logic [2:0] req, elig, pick;

    assign req = {rx_req, tx_req, init_req};

`ifdef ETH_ARB_TIMEOUT_EN
    logic [15:0] own_q, own_d;
    logic [2:0]  mask_q, mask_d;
    logic        terr_q, terr_d;
    assign elig        = req & ~mask_q;
    assign timeout_err = terr_q;
`else
    assign elig        = req;
    assign timeout_err = 1'b0;
`endif

    // Init always wins; TX/RX only after init, ties go to whoever did not own the bus last
    assign pick = elig[0] ? 3'b001 :
                  !init_done_q ? 3'b000 :
                  (elig[1] && elig[2]) ? (last_rx_q ? 3'b010 : 3'b100) :
                  elig[1] ? 3'b010 :
                  elig[2] ? 3'b100 : 3'b000;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        turn_d      = turn_q;
        last_rx_d   = last_rx_q;
        init_done_d = init_done_q;
`ifdef ETH_ARB_TIMEOUT_EN
        own_d       = own_q;
        terr_d      = 1'b0;
        mask_d      = mask_q & req;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = pick;
                if (pick != 3'b000) begin
                    state_d   = S_GRANT;
                    last_rx_d = pick[0] ? last_rx_q : pick[2];
`ifdef ETH_ARB_TIMEOUT_EN
                    own_d     = 16'd0;
`endif
                end
            end
            S_GRANT: begin
                if ((gnt_q & req) == 3'b000) begin
                    gnt_d       = 3'b000;
                    init_done_d = init_done_q | gnt_q[0];
                    state_d     = (TURN_CYCLES == 1) ? S_IDLE : S_TURN;
                    turn_d      = 4'(TURN_CYCLES - 1);
                end
`ifdef ETH_ARB_TIMEOUT_EN
                else if (own_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    gnt_d   = 3'b000;
                    terr_d  = 1'b1;
                    mask_d  = (mask_q & req) | gnt_q;
                    state_d = (TURN_CYCLES == 1) ? S_IDLE : S_TURN;
                    turn_d  = 4'(TURN_CYCLES - 1);
                end else begin
                    own_d = own_q + 16'd1;
                end
`endif
            end
            S_TURN: begin
                turn_d  = turn_q - 4'd1;
                state_d = (turn_q == 4'd1) ? S_IDLE : S_TURN;
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = S_IDLE;
            end
        endcase
        ctl_d  = gnt_d[0] ? 2'b00 : gnt_d[1] ? 2'b01 : gnt_d[2] ? 2'b10 : 2'b11;
        busy_d = state_d != S_IDLE;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 3'b000;
            ctl_q       <= 2'b11;
            turn_q      <= 4'd0;
            last_rx_q   <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ETH_ARB_TIMEOUT_EN
            own_q       <= 16'd0;
            mask_q      <= 3'b000;
            terr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ctl_q       <= ctl_d;
            turn_q      <= turn_d;
            last_rx_q   <= last_rx_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
`ifdef ETH_ARB_TIMEOUT_EN
            own_q       <= own_d;
            mask_q      <= mask_d;
            terr_q      <= terr_d;
`endif
        end
    end

    assign init_gnt  = gnt_q[0];
    assign tx_gnt    = gnt_q[1];
    assign rx_gnt    = gnt_q[2];
    assign ctl       = ctl_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_eth_bus_arbiter.sv
// tb_eth_bus_arbiter: randomized bench comparing eth_bus_arbiter against a cycle-level ownership model.
module tb_eth_bus_arbiter;
    localparam int TURN = 2;
    localparam int TO   = 8;
`ifdef ETH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset = 1'b1, init_req = 1'b0, tx_req = 1'b0, rx_req = 1'b0;
    logic       init_gnt, tx_gnt, rx_gnt, init_done, busy, timeout_err;
    logic [1:0] ctl;

    always #5 sysclk = ~sysclk;

    eth_bus_arbiter #(.TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TO)) dut (
        .sysclk(sysclk), .reset(reset), .init_req(init_req), .tx_req(tx_req), .rx_req(rx_req),
        .init_gnt(init_gnt), .tx_gnt(tx_gnt), .rx_gnt(rx_gnt), .ctl(ctl),
        .init_done(init_done), .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0, failures = 0, cyc = 0;
    int owner = -1, held = 0, idle = TURN;
    bit last_rx = 0, done = 0, terr = 0;
    bit [2:0] mask = 3'b000;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge of the reference: who owns the bus, how long, and how many idle cycles have been shown
    task automatic model_step();
        bit [2:0] r, e, m_old;
        int pick;
        r = {rx_req, tx_req, init_req};
        pick = -1;
        if (reset) begin
            owner = -1; held = 0; idle = TURN; last_rx = 0; done = 0; terr = 0; mask = 3'b000;
            return;
        end
        terr  = 0;
        m_old = mask;
        mask  = mask & r;
        if (owner >= 0) begin
            if (!r[owner]) begin
                if (owner == 0) done = 1;
                owner = -1; idle = 1;
            end else if (TO_EN && held == TO) begin
                mask[owner] = 1'b1; terr = 1; owner = -1; idle = 1;
            end else held++;
        end else if (idle >= TURN) begin
            e = r & ~m_old;
            if (e[0]) pick = 0;
            else if (done) begin
                if (e[1] && e[2]) pick = last_rx ? 1 : 2;
                else if (e[1]) pick = 1;
                else if (e[2]) pick = 2;
            end
            if (pick >= 0) begin
                owner = pick; held = 1;
                if (pick > 0) last_rx = (pick == 2);
            end
        end else idle++;
    endtask

    task automatic check_all();
        bit [2:0] g;
        g = (owner >= 0) ? 3'(1 << owner) : 3'b000;
        chk("gnt", {1'b0, rx_gnt, tx_gnt, init_gnt}, {1'b0, g});
        chk("ctl", {2'b00, ctl}, (owner >= 0) ? 4'(owner) : 4'd3);
        chk("init_done", {3'b000, init_done}, {3'b000, done});
        chk("busy", {3'b000, busy}, {3'b000, (owner >= 0 || idle < TURN)});
        chk("timeout_err", {3'b000, timeout_err}, {3'b000, terr});
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        #1;
        cyc++;
        check_all();
        @(negedge sysclk);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tx_req = 1'b1; rx_req = 1'b1;
        repeat (10) tick();
        chk("no_gnt_before_init", {1'b0, rx_gnt, tx_gnt, init_gnt}, 4'd0);
        tx_req = 1'b0; rx_req = 1'b0; init_req = 1'b1;
        repeat (5) tick();
        chk("init_held", {2'b00, ctl}, 4'd0);
        init_req = 1'b0;
        repeat (3) tick();
        chk("init_done_set", {3'b000, init_done}, 4'd1);
        tx_req = 1'b1; rx_req = 1'b1;
        tick();
        chk("rx_first", {2'b00, ctl}, 4'd2);
        repeat (3) tick();
        rx_req = 1'b0;
        repeat (3) tick();
        chk("tx_after_gap", {2'b00, ctl}, 4'd1);
        init_req = 1'b1; rx_req = 1'b1;
        repeat (2) tick();
        tx_req = 1'b0;
        repeat (3) tick();
        chk("init_before_rx", {2'b00, ctl}, 4'd0);
        init_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("reset_mid", {2'b00, ctl}, 4'd3);
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            init_req = init_req ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 39) == 0);
            tx_req   = tx_req ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 3) == 0);
            rx_req   = rx_req ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 3) == 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
